pwm_duty_ctrl: RTL

//  Rotary-encoder-driven duty-cycle controller for the 4-channel PWM generator.

---
 rtl/pwm_duty_ctrl_if.sv | 26 ++
 rtl/pwm_duty_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ctrl_if.sv
// Signal bundle between the encoder/button/PWM side and the duty-cycle controller.
// master = board/PWM side driving the raw inputs, slave = pwm_duty_ctrl.
interface pwm_duty_ctrl_if #(
    parameter int CH = 4,
    parameter int DW = 8
);
    localparam int SW = (CH > 1) ? $clog2(CH) : 1;

    logic              enc_a;
    logic              enc_b;
    logic              btn;
    logic              frame_start;
    logic [CH*DW-1:0]  duty;
    logic [SW-1:0]     sel;
    logic              update;

    modport master (
        output enc_a, enc_b, btn, frame_start,
        input  duty, sel, update
    );

    modport slave (
        input  enc_a, enc_b, btn, frame_start,
        output duty, sel, update
    );
endinterface

// File: rtl/pwm_duty_ctrl.sv
// Rotary-encoder duty controller: quadrature decode, debounced channel select, per-channel
// working duties copied to the PWM shadow bus on frame boundaries. PWM_CTRL_WRAP_EN selects wrapping steps.
module pwm_duty_ctrl #(
    parameter int               CH        = 4,
    parameter int               DW        = 8,
    parameter int               STEP      = 8,
    parameter int               DEB_CYC   = 16,
    parameter logic [CH*DW-1:0] INIT_DUTY = 32'hCC99_6633
) (
    input  logic                clk,
    input  logic                rst,
    pwm_duty_ctrl_if.slave      bus
);
    localparam int SW    = (CH > 1) ? $clog2(CH) : 1;
    localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic [2:0]        s1_reg, s2_reg;
    logic [1:0]        prev_ab_reg;
    logic signed [2:0] acc_reg, acc_next;
    logic              inc_reg, dec_reg, inc_next, dec_next;
    logic              btn_last_reg, btn_acc_reg, btn_acc_next;
    logic [CNT_W-1:0]  deb_cnt_reg, deb_cnt_next;
    logic [SW-1:0]     sel_reg, sel_next;
    logic              pending_reg, pending_next;
    logic              update_reg;

    logic [1:0]        ab_cur, idx_diff;
    logic              btn_sync, stable, press, reload, wr_en;
    logic signed [3:0] delta, acc_sum;
    logic [DW-1:0]     cur_w, new_w;
    logic [DW:0]       sum_ext, dif_ext;
    logic [DW-1:0]     w_vec [CH];

    // Gray position of an AB pair along the forward sequence 00-01-11-10.
    function automatic logic [1:0] ab_to_idx(input logic [1:0] ab);
        case (ab)
            2'b00:   ab_to_idx = 2'd0;
            2'b01:   ab_to_idx = 2'd1;
            2'b11:   ab_to_idx = 2'd2;
            default: ab_to_idx = 2'd3;
        endcase
    endfunction

    assign ab_cur   = s2_reg[2:1];
    assign btn_sync = s2_reg[0];

    always_comb begin
        idx_diff = ab_to_idx(ab_cur) - ab_to_idx(prev_ab_reg);
        delta    = 4'sd0;
        if (idx_diff == 2'd1)
            delta = 4'sd1;
        else if (idx_diff == 2'd3)
            delta = -4'sd1;
        acc_sum  = $signed({acc_reg[2], acc_reg}) + delta;
        inc_next = (acc_sum == 4'sd4);
        dec_next = (acc_sum == -4'sd4);
        acc_next = (inc_next || dec_next) ? 3'sd0 : acc_sum[2:0];
    end

    // A level is accepted once it has been seen unchanged for DEB_CYC consecutive samples.
    always_comb begin
        stable       = (btn_sync == btn_last_reg);
        deb_cnt_next = deb_cnt_reg;
        btn_acc_next = btn_acc_reg;
        if (!stable)
            deb_cnt_next = '0;
        else if (deb_cnt_reg == CNT_W'(DEB_CYC - 1))
            btn_acc_next = btn_sync;
        else
            deb_cnt_next = deb_cnt_reg + 1'b1;
        press    = btn_acc_next & ~btn_acc_reg;
        sel_next = sel_reg;
        if (press)
            sel_next = (sel_reg == SW'(CH - 1)) ? '0 : sel_reg + 1'b1;
    end

    always_comb begin
        cur_w   = w_vec[sel_reg];
        sum_ext = {1'b0, cur_w} + (DW+1)'(STEP);
        dif_ext = {1'b0, cur_w} - (DW+1)'(STEP);
`ifdef PWM_CTRL_WRAP_EN
        new_w = inc_reg ? sum_ext[DW-1:0] : dif_ext[DW-1:0];
        wr_en = inc_reg | dec_reg;
`else
        if (inc_reg)
            new_w = sum_ext[DW] ? {DW{1'b1}} : sum_ext[DW-1:0];
        else
            new_w = dif_ext[DW] ? {DW{1'b0}} : dif_ext[DW-1:0];
        // A step pinned at a rail is not a write, so it must not request a reload.
        wr_en = (inc_reg | dec_reg) && (new_w != cur_w);
`endif
        reload       = bus.frame_start && pending_reg;
        pending_next = wr_en ? 1'b1 : (bus.frame_start ? 1'b0 : pending_reg);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_reg       <= '0;
            s2_reg       <= '0;
            prev_ab_reg  <= '0;
            acc_reg      <= '0;
            inc_reg      <= 1'b0;
            dec_reg      <= 1'b0;
            btn_last_reg <= 1'b0;
            deb_cnt_reg  <= '0;
            btn_acc_reg  <= 1'b0;
            sel_reg      <= '0;
            pending_reg  <= 1'b0;
            update_reg   <= 1'b0;
        end else begin
            s1_reg       <= {bus.enc_a, bus.enc_b, bus.btn};
            s2_reg       <= s1_reg;
            prev_ab_reg  <= ab_cur;
            acc_reg      <= acc_next;
            inc_reg      <= inc_next;
            dec_reg      <= dec_next;
            btn_last_reg <= btn_sync;
            deb_cnt_reg  <= deb_cnt_next;
            btn_acc_reg  <= btn_acc_next;
            sel_reg      <= sel_next;
            pending_reg  <= pending_next;
            update_reg   <= reload;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic [DW-1:0] w_reg;
            logic [DW-1:0] shadow_reg;

            // Shadow samples the pre-step working value when a write and a reload coincide.
            always_ff @(posedge clk) begin
                if (rst) begin
                    w_reg      <= INIT_DUTY[gi*DW +: DW];
                    shadow_reg <= INIT_DUTY[gi*DW +: DW];
                end else begin
                    if (wr_en && (sel_reg == SW'(gi)))
                        w_reg <= new_w;
                    if (reload)
                        shadow_reg <= w_reg;
                end
            end

            assign w_vec[gi]                = w_reg;
            assign bus.duty[gi*DW +: DW]    = shadow_reg;
        end
    endgenerate

    assign bus.sel    = sel_reg;
    assign bus.update = update_reg;
endmodule
